p_reduce_seq: RTL

Streaming, parametrised successor to the combinational parallel-AND reducer. It accepts NB_INS buses of BUS_WIDTH bits one beat per cycle over a valid/ready input and folds them into an accumulator with a selectable bitwise operator (AND/OR/XOR/NAND). It presents one reduced word per frame on a valid/ready output. It sits between operand producers and the ALU boolean path wherever operands arrive serially instead of as a parallel array.

---
 rtl/p_reduce_seq_if.sv | 22 ++
 rtl/p_reduce_seq.sv | 100 ++++++++++
 2 files changed

// File: rtl/p_reduce_seq_if.sv
// Valid/ready operand and result channels of the streaming bitwise reducer.
// The producer/consumer side uses master; the reducer uses slave.
interface p_reduce_seq_if #(
  parameter int BUS_WIDTH = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [BUS_WIDTH-1:0] in_bus;
  logic                 out_valid;
  logic                 out_ready;
  logic [BUS_WIDTH-1:0] out_bus;

  modport master (
    output in_valid, in_bus, out_ready,
    input  in_ready, out_valid, out_bus
  );

  modport slave (
    input  in_valid, in_bus, out_ready,
    output in_ready, out_valid, out_bus
  );
endinterface

// File: rtl/p_reduce_seq.sv
// Streaming reducer: folds NB_INS operands per frame with AND/OR/XOR/NAND
// and presents one result per frame on a valid/ready output.
//
// state | meaning
// IDLE  | waiting for a frame's first operand
// ACCUM | folding operands 2..NB_INS into acc
// DONE  | result held on out_bus until accepted or flushed
module p_reduce_seq #(
  parameter int BUS_WIDTH = 4,
  parameter int NB_INS    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] op,
  input  logic       flush,
  p_reduce_seq_if.slave bus
);
  localparam int CW = $clog2(NB_INS) + 1;
  localparam logic [CW-1:0] LAST = CW'(NB_INS);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]           state;
  logic [BUS_WIDTH-1:0] acc;
  logic [CW-1:0]        count;
  logic [1:0]           op_q;
  logic                 out_valid_q;
  logic [BUS_WIDTH-1:0] out_bus_q;

  logic                 in_ready;
  logic                 beat;
  logic [1:0]           op_eff;
  logic [CW-1:0]        cnt_nx;
  logic [BUS_WIDTH-1:0] fold;
  logic [BUS_WIDTH-1:0] acc_nx;
  logic [BUS_WIDTH-1:0] res;

  assign in_ready      = !rst && !flush && (state != DONE);
  assign beat          = bus.in_valid && in_ready;
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_bus   = out_bus_q;

  // The first beat of a frame uses the live op; later beats use the latched one.
  always_comb begin
    op_eff = (state == IDLE) ? op : op_q;
    cnt_nx = (state == IDLE) ? CW'(1) : count + CW'(1);
    case (op_eff)
      2'b01:   fold = acc | bus.in_bus;
      2'b10:   fold = acc ^ bus.in_bus;
      default: fold = acc & bus.in_bus;
    endcase
    acc_nx = (state == IDLE) ? bus.in_bus : fold;
    res    = (op_eff == 2'b11) ? ~acc_nx : acc_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      acc         <= '0;
      count       <= '0;
      op_q        <= 2'b00;
      out_valid_q <= 1'b0;
      out_bus_q   <= '0;
    end else if (flush) begin
      state       <= IDLE;
      acc         <= '0;
      count       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (beat) begin
            acc   <= acc_nx;
            count <= cnt_nx;
            if (state == IDLE)
              op_q <= op;
            if (cnt_nx == LAST) begin
              state       <= DONE;
              out_bus_q   <= res;
              out_valid_q <= 1'b1;
            end else begin
              state <= ACCUM;
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            count       <= '0;
            out_valid_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
